// File: rtl/apb_master_n_if.sv
// Request/response and APB completer signals for apb_master_n.
// The master modport is the DUT view and the slave modport is the requester/completer view.
interface apb_master_n_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 4
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [STRB_WIDTH-1:0] req_strb;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [STRB_WIDTH-1:0] PSTRB;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb,
    input  PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb,
    output PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_master_n.sv
// APB requester bridging a valid/ready request port onto NUM_SLAVES PSEL lines.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_n #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_master_n_if.master  bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SEL_BITS   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  err_pend_q, err_pend_d;

  logic [SEL_BITS-1:0]   req_idx;
  logic                  req_idx_ok;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  accept;
  logic                  timeout;

  assign req_idx    = bus.req_addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign req_idx_ok = (32'(req_idx) < NUM_SLAVES);

  always_comb begin
    req_onehot = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      req_onehot[i] = (32'(req_idx) == i);
    end
  end

  assign bus.req_ready = (state_q == IDLE) || ((state_q == ACCESS) && bus.PREADY);
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    timeout    = 1'b0;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !bus.PREADY) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      timeout    = (32'(wait_cnt_d) == TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  // No wait counter: ACCESS holds until PREADY, TIMEOUT_CYCLES is inert.
  assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_pend_d  = 1'b0;

    if (err_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = '0;
    end

    case (state_q)
      IDLE: ;
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.PSLVERR;
          if (!pwrite_q) rsp_rdata_d = bus.PRDATA;
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = IDLE;
          psel_d      = '0;
          penable_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (req_idx_ok) begin
        state_d   = SETUP;
        psel_d    = req_onehot;
        penable_d = 1'b0;
        pwrite_d  = bus.req_write;
        paddr_d   = bus.req_addr;
        pwdata_d  = bus.req_wdata;
        pstrb_d   = bus.req_write ? bus.req_strb : '0;
      end else if (rsp_valid_d) begin
        // Completion response already owns the next cycle; the error follows one cycle later.
        err_pend_d = 1'b1;
      end else begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = '0;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.PSTRB     = pstrb_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
